// File: rtl/dm_cache_wb.sv
// dm_cache_wb: direct-mapped write-back write-allocate cache with burst refill and writeback
module dm_cache_wb #(
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 32,
   parameter int INDEX_W  = 10,
   parameter int OFFSET_W = 2,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES = 2**INDEX_W;
   typedef enum logic [2:0] {IDLE, LOOKUP, RESPOND, WRITEBACK, REFILL} state_t;
   state_t state;
   logic [DATA_W-1:0] data_mem [0:(2**(INDEX_W+OFFSET_W))-1];
   logic [TAG_W-1:0] tag_mem [0:LINES-1];
   logic [LINES-1:0] valid, dirty;
   logic req_we, post, hit, ack, last, data_we, tag_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata, data_wd;
   logic [OFFSET_W-1:0] off, nxt_off, woff;
   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [INDEX_W+OFFSET_W-1:0] data_wa;

   // address split, hit detection and array write controls
   always_comb begin
      idx = req_addr[OFFSET_W +: INDEX_W];
      tag = req_addr[ADDR_W-1 -: TAG_W];
      woff = req_addr[OFFSET_W-1:0];
      nxt_off = off + OFFSET_W'(1);
      hit = valid[idx] && tag_mem[idx] == tag;
      ack = mem_req && mem_ack;
      last = &off;
      data_we = (state == LOOKUP && hit && req_we) || (state == REFILL && ack);
      data_wa = state == REFILL ? {idx, off} : {idx, woff};
      data_wd = state == REFILL ? mem_rdata : req_wdata;
      tag_we = state == REFILL && ack && last;
   end

   // tag and data storage, kept out of reset so it maps onto plain RAM
   always_ff @(posedge clk) begin
      if (data_we) data_mem[data_wa] <= data_wd;
      if (tag_we) tag_mem[idx] <= tag;
   end

   // control FSM with valid/dirty bits, saturating counters and registered port outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
         hit_count <= '0;
         miss_count <= '0;
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         mem_req <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         req_we <= 1'b0;
         req_addr <= '0;
         req_wdata <= '0;
         post <= 1'b0;
         off <= '0;
      end else begin
         cpu_ready <= 1'b0;
         case (state)
            IDLE: if (cpu_req) begin
               req_we <= cpu_we;
               req_addr <= cpu_addr;
               req_wdata <= cpu_wdata;
               post <= 1'b0;
               state <= LOOKUP;
            end
            LOOKUP: if (hit) begin
               if (req_we) dirty[idx] <= 1'b1;
               else cpu_rdata <= data_mem[{idx, woff}];
               if (!post && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
               cpu_ready <= 1'b1;
               state <= RESPOND;
            end else begin
               if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
               off <= '0;
               state <= valid[idx] && dirty[idx] ? WRITEBACK : REFILL;
            end
            RESPOND: state <= IDLE;
            WRITEBACK: if (!mem_req) begin
               mem_req <= 1'b1;
               mem_we <= 1'b1;
               mem_addr <= {tag_mem[idx], idx, off};
               mem_wdata <= data_mem[{idx, off}];
            end else if (mem_ack) begin
               off <= nxt_off;
               if (last) begin
                  mem_req <= 1'b0;
                  state <= REFILL;
               end else begin
                  mem_addr <= {tag_mem[idx], idx, nxt_off};
                  mem_wdata <= data_mem[{idx, nxt_off}];
               end
            end
            REFILL: if (!mem_req) begin
               mem_req <= 1'b1;
               mem_we <= 1'b0;
               mem_addr <= {tag, idx, off};
            end else if (mem_ack) begin
               off <= nxt_off;
               if (last) begin
                  mem_req <= 1'b0;
                  valid[idx] <= 1'b1;
                  dirty[idx] <= 1'b0;
                  post <= 1'b1;
                  state <= LOOKUP;
               end else mem_addr <= {tag, idx, nxt_off};
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dm_cache_wb.sv
// tb_dm_cache_wb: randomized scoreboard bench checking dm_cache_wb against a behavioural cache model
module tb_dm_cache_wb;
   localparam int AW = 15, DW = 32, IW = 10, OW = 2, CW = 4, WPL = 2**OW, SAT = 2**CW - 1;
   logic clk, rst_n, cpu_req, cpu_we, cpu_ready, mem_req, mem_we, mem_ack;
   logic [AW-1:0] cpu_addr, mem_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
   logic [CW-1:0] hit_count, miss_count;

   typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } mtx_t;
   typedef struct { logic ld; logic [DW-1:0] data; int hits; int misses; int lat; int cyc0; } rsp_t;
   mtx_t exp_mem[$];
   rsp_t exp_rsp[$];
   rsp_t mon_r;
   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] ref_mem [2**AW];
   int m_tag [2**IW];
   bit m_valid [2**IW];
   bit m_dirty [2**IW];
   int m_hits, m_misses, tests, fails, cyc, rsp_seen;

   dm_cache_wb #(.ADDR_W(AW), .DATA_W(DW), .INDEX_W(IW), .OFFSET_W(OW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_valid[i]) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      foreach (mem[i]) ref_mem[i] = mem[i];
      m_hits = 0;
      m_misses = 0;
      exp_mem.delete();
      exp_rsp.delete();
   endtask

   // what a direct-mapped write-back cache must do for one access, stated with line arithmetic
   task automatic model_access(input logic we, input int addr, input logic [DW-1:0] wd);
      int idx, tg, base, old;
      mtx_t t;
      rsp_t r;
      idx = (addr / WPL) % (2**IW);
      tg = addr / (WPL * 2**IW);
      base = addr - addr % WPL;
      r.lat = -1;
      if (m_valid[idx] && m_tag[idx] == tg) begin
         if (m_hits < SAT) m_hits++;
         r.lat = 2;
      end else begin
         if (m_misses < SAT) m_misses++;
         if (m_valid[idx] && m_dirty[idx]) begin
            old = (m_tag[idx] * 2**IW + idx) * WPL;
            for (int o = 0; o < WPL; o++) begin
               t.we = 1'b1;
               t.addr = AW'(old + o);
               t.data = ref_mem[old + o];
               exp_mem.push_back(t);
            end
         end
         for (int o = 0; o < WPL; o++) begin
            t.we = 1'b0;
            t.addr = AW'(base + o);
            t.data = '0;
            exp_mem.push_back(t);
         end
         m_valid[idx] = 1'b1;
         m_tag[idx] = tg;
         m_dirty[idx] = 1'b0;
      end
      if (we) begin
         ref_mem[addr] = wd;
         m_dirty[idx] = 1'b1;
      end
      r.ld = !we;
      r.data = ref_mem[addr];
      r.hits = m_hits;
      r.misses = m_misses;
      r.cyc0 = cyc;
      exp_rsp.push_back(r);
   endtask

   task automatic start_access(input logic we, input int addr, input logic [DW-1:0] wd);
      @(negedge clk);
      model_access(we, addr, wd);
      cpu_req = 1'b1;
      cpu_we = we;
      cpu_addr = AW'(addr);
      cpu_wdata = wd;
      @(negedge clk);
      cpu_req = 1'b0;
   endtask

   task automatic access(input logic we, input int addr, input logic [DW-1:0] wd);
      int seen, n;
      seen = rsp_seen;
      n = 0;
      start_access(we, addr, wd);
      while (rsp_seen == seen && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("access_complete", 64'(rsp_seen != seen), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      cpu_req = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // response monitor: pops the scoreboard whenever the cache completes an access
   always @(negedge clk) begin
      if (rst_n && cpu_ready) begin
         if (exp_rsp.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ready: got cpu_ready=1 expected no pending access");
         end else begin
            mon_r = exp_rsp.pop_front();
            if (mon_r.ld) check("cpu_rdata", cpu_rdata, mon_r.data);
            check("hit_count", hit_count, mon_r.hits);
            check("miss_count", miss_count, mon_r.misses);
            if (mon_r.lat >= 0) check("hit_latency", cyc - mon_r.cyc0, mon_r.lat);
         end
         rsp_seen++;
      end
   end

   // memory responder: random ack delay, checks each word against the expected burst order
   initial begin
      bit pend;
      int d;
      mtx_t cap, e;
      pend = 1'b0;
      d = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (!rst_n) pend = 1'b0;
         else begin
            if (pend) begin
               check("mem_req_held", mem_req, 1);
               check("mem_addr_held", mem_addr, cap.addr);
               check("mem_we_held", mem_we, cap.we);
               if (cap.we) check("mem_wdata_held", mem_wdata, cap.data);
            end else if (mem_req) begin
               pend = 1'b1;
               cap.we = mem_we;
               cap.addr = mem_addr;
               cap.data = mem_wdata;
               d = $urandom_range(0, 5);
               if (exp_mem.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_mem_req: got addr %0h we %0b expected no request", mem_addr, mem_we);
               end else begin
                  e = exp_mem.pop_front();
                  check("mem_we", mem_we, e.we);
                  check("mem_addr", mem_addr, e.addr);
                  if (e.we) check("mem_wdata", mem_wdata, e.data);
               end
            end
            if (pend) begin
               if (d == 0) begin
                  mem_ack = 1'b1;
                  pend = 1'b0;
                  if (cap.we) mem[cap.addr] = cap.data;
                  else mem_rdata = mem[cap.addr];
               end else d--;
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no end of run expected finish");
      $fatal(1);
   end

   initial begin
      int n, addr;
      int idxs [4];
      idxs = '{0, 1, 5, 1023};
      tests = 0;
      fails = 0;
      cyc = 0;
      rsp_seen = 0;
      rst_n = 1'b0;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
      foreach (mem[i]) mem[i] = 32'hA5A5_0000 | 32'(i);
      model_reset();
      #12;
      check("rst_cpu_ready", cpu_ready, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_hit_count", hit_count, 0);
      check("rst_miss_count", miss_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      access(0, 'h0010, 0);
      access(0, 'h0011, 0);
      access(1, 'h0011, 32'hDEAD_BEEF);
      access(0, 'h1011, 0);
      check("wb_word1", mem['h11], 32'hDEAD_BEEF);
      access(0, 'h0011, 0);
      access(1, 'h7FFF, 32'h1234_5678);
      access(0, 'h7FFF, 0);
      access(0, 'h3FFC, 0);
      access(0, 'h7FFF, 0);
      do_reset();
      access(0, 'h0040, 0);
      for (int k = 0; k < 20; k++) access(0, 'h0040 + k % WPL, 0);
      check("hit_saturated", hit_count, SAT);
      do_reset();
      start_access(0, 'h2468, 0);
      n = 0;
      while (!(mem_req && !mem_we) && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midburst_mem_req", mem_req, 0);
      check("midburst_hit_count", hit_count, 0);
      check("midburst_miss_count", miss_count, 0);
      cpu_req = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      access(0, 'h2468, 0);
      check("rerun_miss_count", miss_count, 1);
      for (int r = 0; r < 8; r++) begin
         do_reset();
         for (int k = 0; k < 30; k++) begin
            addr = ($urandom_range(0, 7) * 2**IW + idxs[$urandom_range(0, 3)]) * WPL + $urandom_range(0, WPL - 1);
            access(1'($urandom_range(0, 1)), addr, $urandom);
         end
      end
      repeat (5) @(negedge clk);
      check("mem_queue_empty", exp_mem.size(), 0);
      check("rsp_queue_empty", exp_rsp.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
